fir_serial_mac: RTL and testbench

FIR_SERIAL_MAC -- requirements
Module: fir_serial_mac

---
 rtl/fir_serial_mac.sv | 143 ++++++++++++++
 tb/tb_fir_serial_mac.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_serial_mac.sv
// Serial-MAC FIR filter: one shared multiplier, circular sample history.
// Define FIR_SAT_EN to saturate the scaled output instead of wrapping.
module fir_serial_mac #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 32,
  parameter int TAPS   = 33,
  parameter int SHIFT  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      bypass,
  input  logic                      coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]   coef_wr_addr,
  input  logic signed [COEF_W-1:0]  coef_wr_data,
  output logic                      coef_wr_ready,
  input  logic signed [DATA_W-1:0]  data_in,
  input  logic                      data_in_valid,
  output logic                      data_in_ready,
  output logic signed [DATA_W-1:0]  data_out,
  output logic                      data_out_valid
);

  localparam int AW    = $clog2(TAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + AW;
  localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);
  localparam logic [AW-1:0] T_MOD  = AW'(TAPS);
  localparam logic [AW:0]   N_TAPS = (AW+1)'(TAPS);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [AW-1:0]             r_wptr;
  logic [AW-1:0]             r_k;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [DATA_W-1:0]  r_hist [TAPS];
  logic signed [COEF_W-1:0]  r_coef [TAPS];
  logic signed [DATA_W-1:0]  r_dout;
  logic                      r_dvalid;

  logic                      w_accept;
  logic                      w_coef_we;
  logic [AW-1:0]             w_idx;
  logic signed [PW-1:0]      w_hx;
  logic signed [PW-1:0]      w_cx;
  logic signed [PW-1:0]      w_prod;
  logic signed [ACC_W-1:0]   w_shr;
  logic signed [DATA_W-1:0]  w_res;

  assign w_accept  = (r_state == S_IDLE) && !bypass
                     && data_in_valid && enable;
  assign w_coef_we = coef_wr_en && (r_state == S_IDLE)
                     && ({1'b0, coef_wr_addr} < N_TAPS);

  // x[ptr-k] modulo TAPS; the true index always fits in AW bits
  assign w_idx  = (r_wptr >= r_k) ? (r_wptr - r_k)
                                  : (r_wptr - r_k + T_MOD);
  assign w_hx   = PW'(r_hist[w_idx]);
  assign w_cx   = PW'(r_coef[r_k]);
  assign w_prod = w_hx * w_cx;
  assign w_shr  = r_acc >>> SHIFT;

`ifdef FIR_SAT_EN
  logic w_ovf_hi;
  logic w_ovf_lo;
  assign w_ovf_hi = !w_shr[ACC_W-1] && (|w_shr[ACC_W-2:DATA_W-1]);
  assign w_ovf_lo =  w_shr[ACC_W-1] && !(&w_shr[ACC_W-2:DATA_W-1]);
  always_comb begin
    w_res = w_shr[DATA_W-1:0];
    if (w_ovf_hi)
      w_res = {1'b0, {(DATA_W-1){1'b1}}};
    else if (w_ovf_lo)
      w_res = {1'b1, {(DATA_W-1){1'b0}}};
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_shr[ACC_W-1:DATA_W];
  assign w_res = w_shr[DATA_W-1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // bypass aborts a computation even while enable is low
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_MAC;
      S_MAC: begin
        if (bypass)
          w_next = S_IDLE;
        else if (enable && (r_k == K_LAST))
          w_next = S_OUT;
      end
      S_OUT: if (bypass || enable) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    coef_wr_ready  = (r_state == S_IDLE);
    data_in_ready  = (r_state == S_IDLE) && !bypass;
    data_out       = bypass ? data_in : r_dout;
    data_out_valid = bypass ? data_in_valid : (r_dvalid && enable);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr   <= '0;
      r_k      <= '0;
      r_acc    <= '0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        r_hist[i] <= '0;
        r_coef[i] <= '0;
      end
    end else begin
      if (w_coef_we)
        r_coef[coef_wr_addr] <= coef_wr_data;
      if (enable)
        r_dvalid <= (r_state == S_OUT) && !bypass;
      if (w_accept) begin
        r_hist[r_wptr] <= data_in;
        r_acc          <= '0;
        r_k            <= '0;
      end
      if ((r_state == S_MAC) && enable && !bypass) begin
        r_acc <= r_acc + ACC_W'(w_prod);
        r_k   <= r_k + 1'b1;
      end
      if ((r_state == S_OUT) && enable && !bypass) begin
        r_dout <= w_res;
        r_wptr <= (r_wptr == K_LAST) ? '0 : r_wptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Bench for fir_serial_mac: vector tables, hand-built corner cases and a
// random run against a convolution model (TAPS=5, 16-bit data/coefs).
module tb_fir_serial_mac;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int T  = 5;
  localparam int SH = 0;
  localparam int AW = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 bypass;
  logic                 coef_wr_en;
  logic [AW-1:0]        coef_wr_addr;
  logic signed [CW-1:0] coef_wr_data;
  logic                 coef_wr_ready;
  logic signed [DW-1:0] data_in;
  logic                 data_in_valid;
  logic                 data_in_ready;
  logic signed [DW-1:0] data_out;
  logic                 data_out_valid;

  fir_serial_mac #(
    .DATA_W(DW), .COEF_W(CW), .TAPS(T), .SHIFT(SH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .bypass(bypass),
    .coef_wr_en(coef_wr_en),
    .coef_wr_addr(coef_wr_addr),
    .coef_wr_data(coef_wr_data),
    .coef_wr_ready(coef_wr_ready),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .data_out(data_out),
    .data_out_valid(data_out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   mdl_c[T];
  int   mdl_x[$];
  vec_t tbl[15];

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // y[n] = sum c[k]*x[n-k], samples before reset count as zero
  function automatic longint model_y();
    longint acc = 0;
    longint lim = longint'(1) << (DW - 1);
    int     n   = mdl_x.size();
    for (int k = 0; k < T; k++)
      if (k < n)
        acc += longint'(mdl_c[k]) * longint'(mdl_x[n-1-k]);
    acc = acc >>> SH;
`ifdef FIR_SAT_EN
    if (acc > lim - 1) acc = lim - 1;
    else if (acc < -lim) acc = -lim;
`else
    acc = acc & ((lim << 1) - 1);
    if (acc >= lim) acc -= (lim << 1);
`endif
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'(($urandom_range(0, 1)));
    bypass = 1'b0;
    coef_wr_en = 1'b0;
    coef_wr_addr = '0;
    coef_wr_data = '0;
    data_in = '0;
    data_in_valid = 1'b0;
    tick();
    @(negedge clk);
    check("rst_dout", data_out, 0);
    check("rst_dvalid", data_out_valid, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", data_in_ready, 1);
    check("rst_cw_ready", coef_wr_ready, 1);
    tick();
    enable = 1'b1;
    mdl_x.delete();
    for (int i = 0; i < T; i++) mdl_c[i] = 0;
  endtask

  task automatic write_coef(input int a, input int d);
    coef_wr_en = 1'b1;
    coef_wr_addr = AW'(a);
    coef_wr_data = CW'(d);
    tick();
    coef_wr_en = 1'b0;
    if (a < T) mdl_c[a] = int'(signed'(CW'(d)));
  endtask

  task automatic load_coefs(input int c0, input int c1, input int c2,
                            input int c3, input int c4);
    write_coef(0, c0);
    write_coef(1, c1);
    write_coef(2, c2);
    write_coef(3, c3);
    write_coef(4, c4);
  endtask

  task automatic send(input logic signed [DW-1:0] x, input bit wr,
                      input logic [AW-1:0] wa, input logic signed [CW-1:0] wd,
                      input string nm, output longint got);
    int lat = -1;
    data_in = x;
    data_in_valid = 1'b1;
    if (wr) begin
      coef_wr_en = 1'b1;
      coef_wr_addr = wa;
      coef_wr_data = wd;
      if (int'(wa) < T) mdl_c[wa] = int'(wd);
    end
    @(negedge clk);
    check({nm, "_rdy"}, data_in_ready, 1);
    tick();
    data_in_valid = 1'b0;
    coef_wr_en = 1'b0;
    mdl_x.push_back(int'(x));
    for (int i = 1; i <= 3 * T; i++) begin
      @(negedge clk);
      if (data_out_valid) begin
        lat = i;
        break;
      end
    end
    check({nm, "_lat"}, lat, T + 2);
    got = data_out;
    tick();
  endtask

  task automatic quiet(input int n, input string nm);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (data_out_valid) seen++;
    end
    check(nm, seen, 0);
    tick();
  endtask

  task automatic run_table(input int lo, input int hi, input string nm);
    longint got;
    for (int i = lo; i <= hi; i++) begin
      send(DW'(tbl[i].x), 1'b0, '0, '0, $sformatf("%s%0d", nm, i), got);
      check($sformatf("%s%0d_y", nm, i), got, tbl[i].y);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    longint got;
    int     lat;
    int     seen;
    logic signed [DW-1:0] rx;
    logic signed [CW-1:0] rd;

    tbl[0] = '{1, 1};   tbl[1] = '{0, 2};   tbl[2] = '{0, 3};
    tbl[3] = '{0, 4};   tbl[4] = '{0, 0};
    tbl[5] = '{1, 1};   tbl[6] = '{2, 3};   tbl[7] = '{3, 6};
    tbl[8] = '{4, 10};  tbl[9] = '{5, 14};  tbl[10] = '{6, 18};
    tbl[11] = '{7, 22}; tbl[12] = '{8, 26}; tbl[13] = '{9, 30};
    tbl[14] = '{10, 34};

    reset = 1'b1;
    enable = 1'b1;
    bypass = 1'b0;
    coef_wr_en = 1'b0;
    coef_wr_addr = '0;
    coef_wr_data = '0;
    data_in = '0;
    data_in_valid = 1'b0;

    // impulse response
    do_reset();
    load_coefs(1, 2, 3, 4, 0);
    run_table(0, 4, "imp");

    // circular history wraps through the pointer
    do_reset();
    load_coefs(1, 1, 1, 1, 0);
    run_table(5, 14, "wrap");
    write_coef(7, 50);
    write_coef(5, 50);
    send(DW'(11), 1'b0, '0, '0, "badaddr", got);
    check("badaddr_y", got, 38);

    // output narrowing
    do_reset();
    write_coef(0, 2);
    send(DW'(20000), 1'b0, '0, '0, "satp", got);
`ifdef FIR_SAT_EN
    check("satp_y", got, 32767);
`else
    check("satp_y", got, -25536);
`endif
    send(-DW'(20000), 1'b0, '0, '0, "satn", got);
`ifdef FIR_SAT_EN
    check("satn_y", got, -32768);
`else
    check("satn_y", got, 25536);
`endif

    // busy handshake, ignored coef write during MAC
    do_reset();
    load_coefs(1, 2, 3, 4, 0);
    data_in = DW'(5);
    data_in_valid = 1'b1;
    tick();
    mdl_x.push_back(5);
    data_in = DW'(7);
    @(negedge clk);
    check("busy_in_ready", data_in_ready, 0);
    check("busy_cw_ready", coef_wr_ready, 0);
    tick();
    coef_wr_en = 1'b1;
    coef_wr_addr = '0;
    coef_wr_data = CW'(100);
    @(negedge clk);
    check("busy_cw_ready2", coef_wr_ready, 0);
    tick();
    coef_wr_en = 1'b0;
    data_in_valid = 1'b0;
    lat = -1;
    for (int i = 3; i <= 3 * T; i++) begin
      @(negedge clk);
      if (data_out_valid) begin
        lat = i;
        break;
      end
    end
    check("busy_lat", lat, T + 2);
    check("busy_y", data_out, 5);
    tick();
    send(DW'(1), 1'b0, '0, '0, "busy2", got);
    check("busy2_y", got, 11);

    // bypass in IDLE, then abort mid-MAC
    do_reset();
    load_coefs(1, 2, 3, 4, 0);
    bypass = 1'b1;
    data_in = -DW'(5);
    data_in_valid = 1'b1;
    @(negedge clk);
    check("byp_in_ready", data_in_ready, 0);
    check("byp_dout", data_out, -5);
    check("byp_dvalid", data_out_valid, 1);
    tick();
    bypass = 1'b0;
    data_in_valid = 1'b0;
    quiet(T + 4, "byp_no_accept");
    data_in = DW'(1);
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    tick();
    bypass = 1'b1;
    data_in = DW'(1234);
    data_in_valid = 1'b1;
    @(negedge clk);
    check("abort_dout", data_out, 1234);
    check("abort_dvalid", data_out_valid, 1);
    tick();
    bypass = 1'b0;
    data_in_valid = 1'b0;
    quiet(2 * T, "abort_no_pulse");
    run_table(0, 4, "postab");

    // enable low freezes the computation
    do_reset();
    load_coefs(1, 2, 3, 4, 0);
    data_in = DW'(3);
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    mdl_x.push_back(3);
    tick();
    enable = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (data_out_valid) seen++;
      tick();
    end
    enable = 1'b1;
    check("stall_quiet", seen, 0);
    lat = -1;
    for (int i = 6; i <= 4 * T; i++) begin
      @(negedge clk);
      if (data_out_valid) begin
        lat = i;
        break;
      end
      tick();
    end
    check("stall_lat", lat, T + 6);
    check("stall_y", data_out, model_y());
    tick();

    // reset in the middle of MAC
    data_in = DW'(9);
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("midrst_dout", data_out, 0);
    check("midrst_dvalid", data_out_valid, 0);
    check("midrst_in_ready", data_in_ready, 1);
    tick();
    reset = 1'b0;
    mdl_x.delete();
    for (int i = 0; i < T; i++) mdl_c[i] = 0;
    @(negedge clk);
    check("midrst_rel_ready", data_in_ready, 1);
    tick();
    quiet(2 * T, "midrst_no_pulse");
    send(DW'(5), 1'b0, '0, '0, "zc0", got);
    check("zc0_y", got, 0);
    send(-DW'(7), 1'b0, '0, '0, "zc1", got);
    check("zc1_y", got, 0);

    // random samples and coefficients vs. convolution model
    do_reset();
    for (int a = 0; a < T; a++) write_coef(a, int'($urandom));
    for (int n = 0; n < 40; n++) begin
      rx = DW'($urandom);
      rd = CW'($urandom);
      send(rx, ($urandom_range(0, 3) == 0), AW'($urandom_range(0, 7)), rd,
           $sformatf("rnd%0d", n), got);
      check($sformatf("rnd%0d_y", n), got, model_y());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
